// File: rtl/avg_pool2d_pkg.sv
// avg_pool2d_pkg: shared constants and element-index helpers for the 4x4 -> 2x2 average pool
package avg_pool2d_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int IN_DIM     = 4;
  localparam int OUT_DIM    = 2;
  localparam int POOL_K     = 2;
  localparam int SUM_W      = DEF_DATA_W + 2;
  function automatic int in_idx(input int r, input int c);
    return IN_DIM * r + c;
  endfunction
  function automatic int out_idx(input int i, input int j);
    return OUT_DIM * i + j;
  endfunction
endpackage

// File: rtl/avg_pool2d_win4.sv
// avg_pool2d_win4: combinational average of four unsigned pixels (truncating, or round-half-up with AVG_POOL_ROUND_EN)
module avg_pool2d_win4 #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] avg
);
  localparam int SW = DATA_W + 2;
  logic [SW-1:0] sum;
  logic [SW-1:0] adj;
  assign sum = SW'(a) + SW'(b) + SW'(c) + SW'(d);
`ifdef AVG_POOL_ROUND_EN
  assign adj = sum + SW'(2);
`else
  assign adj = sum;
`endif
  assign avg = DATA_W'(adj >> 2);
endmodule

// File: rtl/avg_pool2d.sv
// avg_pool2d: registered 2x2/stride-2 average pool of a flattened 4x4 matrix; ports clk, rst (async high), data_in_flat, data_out_flat; option macro AVG_POOL_ROUND_EN
module avg_pool2d
  import avg_pool2d_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [16*DATA_W-1:0]  data_in_flat,
  output logic [4*DATA_W-1:0]   data_out_flat
);
  logic [4*DATA_W-1:0] pooled;
  for (genvar i = 0; i < OUT_DIM; i++) begin : g_row
    for (genvar j = 0; j < OUT_DIM; j++) begin : g_col
      avg_pool2d_win4 #(.DATA_W(DATA_W)) u_win (
        .a   (data_in_flat[(16-in_idx(POOL_K*i,   POOL_K*j  ))*DATA_W-1 -: DATA_W]),
        .b   (data_in_flat[(16-in_idx(POOL_K*i,   POOL_K*j+1))*DATA_W-1 -: DATA_W]),
        .c   (data_in_flat[(16-in_idx(POOL_K*i+1, POOL_K*j  ))*DATA_W-1 -: DATA_W]),
        .d   (data_in_flat[(16-in_idx(POOL_K*i+1, POOL_K*j+1))*DATA_W-1 -: DATA_W]),
        .avg (pooled[(4-out_idx(i, j))*DATA_W-1 -: DATA_W])
      );
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) data_out_flat <= '0;
    else     data_out_flat <= pooled;
endmodule

// File: tb/tb_avg_pool2d.sv
// tb_avg_pool2d: table-driven self-checking bench for avg_pool2d
module tb_avg_pool2d;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] data_in_flat = '0;
  logic [31:0]  data_out_flat;
  int checks = 0;
  int failures = 0;
  typedef struct {
    string        name;
    logic [127:0] din;
    logic [31:0]  exp;
  } vec_t;
  vec_t vecs [6];
  avg_pool2d #(.DATA_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in_flat  (data_in_flat),
    .data_out_flat (data_out_flat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  localparam logic [127:0] A_IN = 128'h04080c10_14181c20_24282c30_34383c40;
  localparam logic [31:0]  A_EX = 32'h0e16_2e36;
  localparam logic [127:0] B_IN = 128'h10101010_10101010_20202020_20202020;
  localparam logic [31:0]  B_EX = 32'h1010_2020;
  initial begin
    vecs[0] = '{"ramp",  A_IN, A_EX};
    vecs[1] = '{"all255", {16{8'hff}}, 32'hffffffff};
    vecs[2] = '{"all0", 128'h0, 32'h0};
    vecs[3] = '{"sum5", 128'h01010000_01020000_00000000_00000000, 32'h01000000};
`ifdef AVG_POOL_ROUND_EN
    vecs[4] = '{"sum7", 128'h01020000_02020000_00000000_00000000, 32'h02000000};
    vecs[5] = '{"mixed", 128'h00000102_00000102_ffff0303_fffe0304, 32'h0002ff03};
`else
    vecs[4] = '{"sum7", 128'h01020000_02020000_00000000_00000000, 32'h01000000};
    vecs[5] = '{"mixed", 128'h00000102_00000102_ffff0303_fffe0304, 32'h0001fe03};
`endif
    data_in_flat = A_IN;
    #1 chk("reset_immediate", data_out_flat, 32'h0);
    repeat (3) @(posedge clk);
    #1 chk("reset_held", data_out_flat, 32'h0);
    @(negedge clk) rst = 1'b0;
    chk("release_no_edge", data_out_flat, 32'h0);
    @(negedge clk) chk("first_edge_load", data_out_flat, A_EX);
    foreach (vecs[n]) begin
      @(negedge clk) data_in_flat = vecs[n].din;
      @(negedge clk) chk(vecs[n].name, data_out_flat, vecs[n].exp);
      @(negedge clk) chk({vecs[n].name, "_stable"}, data_out_flat, vecs[n].exp);
    end
    @(negedge clk) data_in_flat = A_IN;
    @(negedge clk) begin
      chk("seq_a", data_out_flat, A_EX);
      data_in_flat = B_IN;
    end
    @(negedge clk) chk("seq_b", data_out_flat, B_EX);
    data_in_flat = A_IN;
    @(negedge clk) chk("seq_a2", data_out_flat, A_EX);
    data_in_flat = B_IN;
    rst = 1'b1;
    #1 chk("mid_reset_async", data_out_flat, 32'h0);
    @(posedge clk) #1 chk("mid_reset_edge", data_out_flat, 32'h0);
    @(negedge clk) rst = 1'b0;
    chk("mid_release_no_edge", data_out_flat, 32'h0);
    @(negedge clk) chk("seq_b_after_reset", data_out_flat, B_EX);
    @(posedge clk) #2 rst = 1'b1;
    #1 chk("async_midcycle", data_out_flat, 32'h0);
    @(negedge clk) rst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/avg_pool2d.md
AVG_POOL2D -- requirements
Module: avg_pool2d

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the unsigned pixel width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port data_in_flat, input, 16*DATA_W (128) bits: the 4x4 input matrix, flattened row-major.
REQ-005 The block SHALL have port data_out_flat, output, 4*DATA_W (32) bits: the 2x2 pooled matrix, flattened row-major, registered.

Function
REQ-006 Input packing SHALL place element (r,c), r,c in 0..3, at index k=4r+c in bits [(16-k)*DATA_W-1 -: DATA_W]; (0,0) occupies [127:120] and (3,3) occupies [7:0].
REQ-007 Output packing SHALL place pooled element (i,j), i,j in 0..1, at index m=2i+j in bits [(4-m)*DATA_W-1 -: DATA_W]; out[0] is [31:24] and out[3] is [7:0].
REQ-008 Pooled element (i,j) SHALL be computed from the non-overlapping 2x2 window: kernel 2, stride 2, no padding, rows 2i..2i+1, columns 2j..2j+1.
REQ-009 Each window sum SHALL be computed unsigned at DATA_W+2 bits so that it never overflows (maximum 4*255=1020).
REQ-010 The average SHALL be sum>>2, truncated toward zero, unless the rounding option (REQ-016) is enabled.
REQ-011 The result SHALL always fit in DATA_W bits; no saturation logic is needed.
REQ-012 data_out_flat SHALL be registered and SHALL reflect data_in_flat sampled at the previous rising clk edge (latency 1 cycle); with a stable input it stays constant.
REQ-013 There is no handshake: the block SHALL recompute on every cycle, and an input change is visible exactly one cycle later.

Reset
REQ-014 While rst=1, data_out_flat SHALL be all zeros immediately (asynchronously) and SHALL remain zero regardless of clk or input.
REQ-015 After rst deasserts, the first rising edge SHALL load the average of the current input; a reset asserted mid-stream SHALL discard the pending result.

Configuration
REQ-016 Macro AVG_POOL_ROUND_EN SHALL select the averaging mode:
- defined: round-half-up, (sum+2)>>2; the maximum is (1020+2)>>2=255, so there is no overflow;
- undefined: truncation, sum>>2.
Interface and latency SHALL be identical in both modes.

Structure
REQ-017 A shared package avg_pool2d_pkg SHALL hold:
- constants IN_DIM=4, OUT_DIM=2, POOL_K=2 and SUM_W=DATA_W+2;
- the element-index helper functions for REQ-006 and REQ-007.
REQ-018 One sub-module, avg_pool2d_win4, SHALL be natural: it is combinational, takes four DATA_W pixels and returns their DATA_W average per REQ-009 to REQ-011 and REQ-016. It SHALL be instantiated four times, with output registers in the top level.

Verification
REQ-019 Assert rst with clk running -> data_out_flat==0 at once and throughout reset.
REQ-020 Ramp input, rows {4,8,12,16},{20,24,28,32},{36,40,44,48},{52,56,60,64}, after reset -> one cycle later outputs [31:24]=14, [23:16]=22, [15:8]=46, [7:0]=54.
REQ-021 All pixels 255 -> all outputs 255; all pixels 0 -> all outputs 0.
REQ-022 Top-left window {1,1,1,2}, all other pixels 0 -> out[0]=1 without the macro and 1 with AVG_POOL_ROUND_EN (sum 5).
REQ-023 Top-left window {1,2,2,2} (sum 7) -> out[0]=1 without the macro and 2 with AVG_POOL_ROUND_EN; out[1..3]=0.
REQ-024 Change input on consecutive cycles A, B -> outputs avg(A) then avg(B) on successive edges; assert rst between them -> output is 0 and B's result appears only after release plus one edge.
